uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter, 8N1 with a rdy/busy handshake, between N_REQ byte producers.
- Arbitrates round-robin among pending requests.
- Sequences the transmitter's rdy pulse / busy handshake for each byte.
- Returns a per-requester completion ack once the stop bit has finished.
- Sits between the system's message sources (status, debug, command echo) and the transmitter instance.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding and frame/baud constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Arbiter FSM states; encodings are fixed so other blocks and debug tools can decode them.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // 8N1 framing levels used by the transmitter.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Default clock and line rate shared with the transmitter instance.
  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above i_ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; o_found is low when no request is set.
// Ports: i_req  - request vector
//        i_ptr  - search start index (must be < N_REQ)
//        o_found - at least one request set
//        o_idx  - chosen requester index
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic             o_found,
  output logic [2:0]       o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [2:0]       w_off;
  logic [3:0]       w_sum;

  // Rotate so that bit 0 of w_rot is the requester at i_ptr.
  assign w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
  assign o_found = |i_req;

  always_comb begin
    w_off = 3'd0;
    // Scan downward so the nearest set bit after the pointer is the last one written.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_idx = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N_REQ byte producers.
// Latency: req to tx_rdy 2 cycles when idle; ack 1 cycle after tx_busy falls.
// Backpressure: requesters hold req until ack; no grant while the transmitter reports busy.
// Ports: i_clk/i_rst       - clock, synchronous active-high reset
//        i_req/i_req_data  - per-requester request and byte ([8i+7:8i])
//        o_ack             - one-cycle completion (or timeout drop) pulse per requester
//        o_grant_id/o_active - requester being served, valid while o_active
//        o_timeout_err     - pulse when tx_busy never rose after tx_rdy
//        o_tx_data/o_tx_rdy/i_tx_busy - transmitter handshake
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_ack,
  output logic [2:0]           o_grant_id,
  output logic                 o_active,
  output logic                 o_timeout_err,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_rdy,
  input  logic                 i_tx_busy
);
  import uart_pkg::*;

  localparam int                TMR_W    = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [2:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic [2:0]        r_grant_id, w_grant_id_nxt;
  logic              r_active, w_active_nxt;
  logic [N_REQ-1:0]  r_ack, w_ack_nxt;
  logic              r_timeout_err, w_timeout_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_tx_rdy, w_tx_rdy_nxt;

  logic              w_found;
  logic [2:0]        w_idx;
  logic [7:0]        w_sel_data;
  logic [N_REQ-1:0]  w_grant_onehot;
  logic [2:0]        w_ptr_adv;
  logic              w_finish;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Datapath helpers: byte of the winning requester, one-hot of the current grant,
  // and the pointer position just past the current grant.
  always_comb begin
    w_sel_data     = 8'h00;
    w_grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == 3'(i))      w_sel_data        = i_req_data[8*i +: 8];
      if (r_grant_id == 3'(i)) w_grant_onehot[i] = 1'b1;
    end
    w_ptr_adv = (r_grant_id == 3'(N_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= 3'd0;
      r_timer       <= '0;
      r_grant_id    <= 3'd0;
      r_active      <= 1'b0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_rdy      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_timer       <= w_timer_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_active      <= w_active_nxt;
      r_ack         <= w_ack_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_rdy      <= w_tx_rdy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_timer_nxt    = r_timer;
    w_grant_id_nxt = r_grant_id;
    w_active_nxt   = r_active;
    w_tx_data_nxt  = r_tx_data;
    w_tx_rdy_nxt   = 1'b0;
    w_ack_nxt      = '0;
    w_timeout_nxt  = 1'b0;
    w_finish       = 1'b0;

    case (r_state)
      IDLE: begin
        // A busy transmitter here means a frame left over from before reset; let it drain.
        if (w_found && !i_tx_busy) begin
          w_grant_id_nxt = w_idx;
          w_tx_data_nxt  = w_sel_data;
          w_active_nxt   = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        w_tx_rdy_nxt = 1'b1;
        w_timer_nxt  = '0;
        w_state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_timer_nxt = '0;
          w_state_nxt = WAIT_DONE;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_nxt = 1'b1;
          w_finish      = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) w_finish = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Completion and timeout both release the requester and move the pointer past it.
    if (w_finish) begin
      w_ack_nxt    = w_grant_onehot;
      w_active_nxt = 1'b0;
      w_rr_ptr_nxt = w_ptr_adv;
      w_timer_nxt  = '0;
      w_state_nxt  = IDLE;
    end
  end

  assign o_ack         = r_ack;
  assign o_grant_id    = r_grant_id;
  assign o_active      = r_active;
  assign o_timeout_err = r_timeout_err;
  assign o_tx_data     = r_tx_data;
  assign o_tx_rdy      = r_tx_rdy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized phase.
// Latency: n/a.
// Backpressure: transmitter model raises busy after each rdy pulse (or never, for timeouts).
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int BT    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     ack;
  logic [2:0]           grant_id;
  logic                 active;
  logic                 timeout_err;
  logic [7:0]           tx_data;
  logic                 tx_rdy;
  logic                 tx_busy;

  uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_data    (req_data),
    .o_ack         (ack),
    .o_grant_id    (grant_id),
    .o_active      (active),
    .o_timeout_err (timeout_err),
    .o_tx_data     (tx_data),
    .o_tx_rdy      (tx_rdy),
    .i_tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state (transaction level).
  bit   m_serving = 0;
  bit   m_saw_busy = 0;
  int   m_ptr = 0;
  int   m_grant = 0;
  int   m_gcyc = 0;
  logic [7:0] m_data = 8'h00;

  // Monitor records.
  int   order[$];
  logic [7:0] rdy_data[$];
  int   rdy_cyc_q[$];
  int   gap_q[$];
  int   ack_cyc = -1, to_cyc = -1, last_fall = -1000;
  logic [N_REQ-1:0] ack_vec = '0;
  logic [7:0] ack_data = 8'h00;
  bit   prev_active = 0, prev_rdy_mon = 0, prev_rdy_tx = 0, prev_busy = 0;
  logic [N_REQ-1:0] inflight = '0;

  // Transmitter model.
  bit   tx_ok = 1, rnd_tx = 0;
  int   tx_d = 1, tx_len = 10, bs = -1000, bl = 0;

  // Requester agent.
  bit   auto_mode = 0;
  int   rearm[N_REQ];
  logic [N_REQ-1:0] rearm_pend = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  task automatic model_step(input logic [N_REQ-1:0] s_req, input logic s_busy, input logic s_rst);
    logic [N_REQ-1:0] e_ack;
    logic e_to, e_rdy;
    e_ack = '0; e_to = 1'b0; e_rdy = 1'b0;
    if (s_rst) begin
      m_serving = 0; m_ptr = 0; m_grant = 0; m_data = 8'h00;
    end else if (m_serving) begin
      if (cyc == m_gcyc + 1) e_rdy = 1'b1;
      else if (!m_saw_busy) begin
        if (s_busy) m_saw_busy = 1;
        else if (cyc == m_gcyc + 1 + BT) begin
          e_to = 1'b1; e_ack[m_grant] = 1'b1; m_serving = 0; m_ptr = (m_grant + 1) % N_REQ;
        end
      end else if (!s_busy) begin
        e_ack[m_grant] = 1'b1; m_serving = 0; m_ptr = (m_grant + 1) % N_REQ;
      end
    end else if (s_req != '0 && !s_busy) begin
      m_grant = pick(s_req, m_ptr);
      m_data = req_data[8*m_grant +: 8];
      m_serving = 1; m_saw_busy = 0; m_gcyc = cyc;
    end
    chk("active", active, m_serving);
    chk("tx_rdy", tx_rdy, e_rdy);
    chk("ack", ack, e_ack);
    chk("timeout_err", timeout_err, e_to);
    if (m_serving || s_rst) begin
      chk("grant_id", grant_id, m_grant);
      chk("tx_data", tx_data, m_data);
    end
  endtask

  task automatic monitor(input logic s_rst);
    if (s_rst) inflight = '0;
    if (active && !prev_active) begin
      order.push_back(int'(grant_id));
      inflight[grant_id] = 1'b1;
    end
    if (tx_rdy && !prev_rdy_mon) begin
      rdy_cyc_q.push_back(cyc);
      rdy_data.push_back(tx_data);
      gap_q.push_back(cyc - last_fall);
    end
    if (|ack) begin
      ack_cyc = cyc; ack_vec = ack; ack_data = tx_data;
      inflight &= ~ack;
    end
    if (timeout_err) to_cyc = cyc;
    prev_active = active;
    prev_rdy_mon = tx_rdy;
  endtask

  task automatic tx_step();
    if (prev_rdy_tx && !tx_rdy) begin
      if (rnd_tx) begin
        tx_ok = ($urandom_range(9) != 0);
        tx_d = $urandom_range(4);
        tx_len = $urandom_range(25, 1);
      end
      if (tx_ok) begin bs = cyc + tx_d; bl = tx_len; end
    end
    prev_rdy_tx = tx_rdy;
    tx_busy = (cyc >= bs) && (cyc < bs + bl);
    if (prev_busy && !tx_busy) last_fall = cyc;
    prev_busy = tx_busy;
  endtask

  task automatic req_step();
    for (int i = 0; i < N_REQ; i++)
      if (rearm_pend[i]) begin req[i] = 1'b1; rearm_pend[i] = 1'b0; end
    for (int i = 0; i < N_REQ; i++)
      if (ack[i]) begin
        req[i] = 1'b0;
        if (rearm[i] > 0) begin rearm[i]--; rearm_pend[i] = 1'b1; end
      end
    if (auto_mode) begin
      for (int i = 0; i < N_REQ; i++)
        if (!req[i] && !ack[i] && !inflight[i] && !rearm_pend[i] && $urandom_range(9) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      if (active && inflight[grant_id]) begin
        if ($urandom_range(39) == 0) req[grant_id] = 1'b0;
        if ($urandom_range(7) == 0) req_data[8*grant_id +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    logic [N_REQ-1:0] s_req;
    logic s_busy, s_rst;
    @(posedge clk);
    #1;
    cyc++;
    s_req = req; s_busy = tx_busy; s_rst = rst;
    model_step(s_req, s_busy, s_rst);
    monitor(s_rst);
    tx_step();
    req_step();
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    int n;
    bit quiet;
    n = 0;
    do begin
      tick();
      n++;
      quiet = (req == '0) && !active && !tx_busy && (rearm_pend == '0);
    end while (!quiet && n < budget);
    chk({tag, "_quiet"}, quiet, 1'b1);
  endtask

  task automatic clear_rec();
    order.delete(); rdy_data.delete(); rdy_cyc_q.delete(); gap_q.delete();
    ack_cyc = -1; to_cyc = -1; ack_vec = '0;
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    chk({tag, "_count"}, order.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < order.size()) ? order[i] : -1, exp[i]);
  endtask

  initial begin
    int r0, be, n;
    int exp_q[$];
    rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    for (int i = 0; i < N_REQ; i++) rearm[i] = 0;

    // Reset values.
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_active", active, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_rdy", tx_rdy, 0);
    rst = 1'b0;
    tick();

    // Single request on index 2, long frame.
    clear_rec();
    tx_ok = 1; tx_d = 0; tx_len = 100;
    r0 = cyc;
    req[2] = 1'b1; req_data[23:16] = 8'h48;
    run_until_quiet("single", 300);
    chk("single_rdy_lat", rdy_cyc_q.size() > 0 ? rdy_cyc_q[0] - r0 : -1, 2);
    chk("single_data", rdy_data.size() > 0 ? rdy_data[0] : 8'hxx, 8'h48);
    chk("single_ack_vec", ack_vec, 4'b0100);
    chk("single_ack_lat", ack_cyc - (bs + bl), 1);

    // Wrap-around: pointer sits at 3 after serving 2.
    clear_rec();
    tx_d = 1; tx_len = 8;
    req = 4'b1001; req_data[31:24] = 8'h33; req_data[7:0] = 8'h30;
    run_until_quiet("wrap", 300);
    exp_q = '{3, 0};
    check_order("wrap_order", exp_q);

    // Reset while the transmitter is mid-frame for requester 2, requester 1 pending.
    clear_rec();
    tx_d = 1; tx_len = 40;
    req[2] = 1'b1; req_data[23:16] = 8'h77;
    for (n = 0; n < 200 && !tx_busy; n++) tick();
    chk("rm_busy_seen", tx_busy, 1'b1);
    repeat (3) tick();
    clear_rec();
    req[1] = 1'b1; req_data[15:8] = 8'h31;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    be = bs + bl;
    tx_len = 6;
    run_until_quiet("rm", 400);
    exp_q = '{1, 2};
    check_order("rm_order", exp_q);
    chk("rm_rdy_after_busy", rdy_cyc_q.size() > 0 ? rdy_cyc_q[0] - be : -1, 2);
    chk("rm_data", rdy_data.size() > 0 ? rdy_data[0] : 8'hxx, 8'h31);

    // Contention from pointer 0, each requester re-asserted once.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    clear_rec();
    tx_d = 2; tx_len = 10;
    rearm[0] = 1; rearm[1] = 1; rearm[3] = 1;
    req_data = {8'h13, 8'h00, 8'h11, 8'h10};
    req = 4'b1011;
    run_until_quiet("cont", 1000);
    exp_q = '{0, 1, 3, 0, 1, 3};
    check_order("cont_order", exp_q);
    exp_q = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
    for (int i = 0; i < 6; i++)
      chk("cont_data", i < rdy_data.size() ? rdy_data[i] : 8'hxx, 8'(exp_q[i]));
    for (int i = 1; i < 6; i++)
      chk("cont_gap", i < gap_q.size() ? gap_q[i] : -1, 3);

    // Timeout: transmitter never goes busy.
    clear_rec();
    tx_ok = 0;
    req[1] = 1'b1; req_data[15:8] = 8'h66;
    run_until_quiet("to", 300);
    chk("to_lat", rdy_cyc_q.size() > 0 ? to_cyc - rdy_cyc_q[0] : -1, BT);
    chk("to_ack_vec", ack_vec, 4'b0010);
    chk("to_ack_cyc", ack_cyc, to_cyc);
    clear_rec();
    tx_ok = 1; tx_d = 1; tx_len = 5;
    req[2] = 1'b1; req_data[23:16] = 8'h22;
    run_until_quiet("to_next", 300);
    exp_q = '{2};
    check_order("to_next_order", exp_q);
    chk("to_next_ack", ack_vec, 4'b0100);

    // Data captured at grant; later changes ignored.
    clear_rec();
    tx_len = 12;
    req[0] = 1'b1; req_data[7:0] = 8'hA5;
    for (n = 0; n < 50 && !active; n++) tick();
    chk("ds_grant_seen", active, 1'b1);
    tick();
    req_data[7:0] = 8'h5A;
    run_until_quiet("ds", 300);
    chk("ds_rdy_data", rdy_data.size() > 0 ? rdy_data[0] : 8'hxx, 8'hA5);
    chk("ds_ack_data", ack_data, 8'hA5);

    // Randomized traffic against the model.
    auto_mode = 1; rnd_tx = 1;
    repeat (3000) tick();
    auto_mode = 0;
    run_until_quiet("rand", 800);
    rnd_tx = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
